clk_divider_nway: RTL
=====================

Name: clk_divider_nway

Overview:
- Runtime-programmable integer clock divider: generates a divided clock of period DIV input-clock cycles, for any DIV >= 2, even or odd.
- Duty cycle is exactly 50% for both even and odd DIV. Odd divisors use a falling-edge half-cycle extension.
- Divisor and enable changes take effect only at output-period boundaries, so the output never produces runt pulses.
- Successor to the even-only divider. Feeds peripheral clock enables and slow interface clocks.

Parameters:
- WIDTH, 8, width of the divisor input and the internal counter. Valid divisors are 2 .. 2^WIDTH-1.

Ports:
- clk  in  1  fast input clock
- reset_n  in  1  reset, asynchronous, active-low
- div  in  WIDTH  requested divide factor, sampled only at load points
- enable  in  1  run request, sampled only at load points
- clk_out  out  1  divided clock, 50% duty
- tick  out  1  one-clk pulse, high in the clk cycle in which a clk_out period starts
- active  out  1  high while the divider is in RUN
- div_err  out  1  high when the last load attempt saw enable=1 with div<2

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, cnt=0, div_q=0, pos_q=0, neg_q=0.
  - clk_out, tick, active and div_err all 0 immediately on reset assertion. A high phase in progress is truncated.
- Load point definition:
  - Every posedge while in IDLE.
  - In RUN, the posedge that ends the last cycle of a period (cnt==div_q-1).
- Load action at a load point:
  - If enable=1 and div>=2: div_q<=div, cnt<=0, pos_q<=1, tick<=1, state<=RUN, div_err<=0.
  - If enable=1 and div<2: state<=IDLE, pos_q<=0, div_err<=1.
  - If enable=0: state<=IDLE, pos_q<=0, div_err<=0.
- RUN, non-load posedges:
  - cnt<=cnt+1, tick<=0.
  - pos_q<=(cnt+1 < floor(div_q/2)).
- Waveform and duty cycle:
  - pos_q is high for floor(div_q/2) cycles per period.
  - neg_q samples pos_q on the negedge of clk.
  - clk_out = pos_q when div_q is even; clk_out = pos_q | neg_q when div_q is odd.
  - Result: high time = div_q/2 clk periods, exactly, for both even and odd div_q.
  - Example, div_q=5: high for 2.5 clk periods, low for 2.5.
- Timing:
  - Latency from the IDLE posedge sampling enable=1 to the clk_out rising edge: 0 cycles. clk_out is registered and rises at that same edge.
  - clk_out period = div_q clk cycles. tick coincides with every clk_out rising edge.
- Divisor change:
  - A new div presented mid-period is ignored until the next load point.
  - The current period always completes at the old div_q.
- Disable:
  - enable dropping mid-period completes the current period, including the full low phase, then enters IDLE with clk_out low.
- active equals (state==RUN).
- Counter width: cnt is WIDTH bits and never wraps, because div_q <= 2^WIDTH-1. Comparisons are unsigned.
- Simultaneous events:
  - enable=1 together with a new div at a load point: the new div is used immediately, giving back-to-back periods with no gap.
  - div<2 and enable=1 at a load point: IDLE plus div_err=1, held until a valid load or an enable=0 load point.
- Reset release mid-stream: the first load point is the first posedge after reset_n rises.

Optional Feature:
- Macro CLKDIV_SYNC_EN.
- When defined:
  - Adds input port sync (1 bit).
  - sync=1 sampled on a posedge while in RUN forces an immediate load point: the period restarts with cnt=0, pos_q=1 and tick=1, using the current div and enable.
  - neg_q is cleared on the same posedge.
  - Used for phase-aligning multiple dividers.
  - sync in IDLE has no extra effect.
- When undefined:
  - No sync port.
  - Load points occur only as described in Behaviour.

Test Plan:
- Even divide: reset, div=4, enable=1 -> clk_out high 2 clk, low 2 clk; tick every 4 cycles; active=1.
- Odd divide and div=3: div=5 -> clk_out high 2.5 clk, low 2.5 clk, measured by edge timestamps. div=3 -> high 1.5 clk, low 1.5 clk.
- Divisor change: div 4->6 written at cnt=1 -> current period completes as 4 cycles, next period is 6 cycles, no runt pulse.
- Disable: enable deasserted mid-high-phase at div=8 -> period completes (8 cycles total), then clk_out=0, active=0. Re-enable -> clk_out rises on the next posedge.
- Invalid divisor and reset: div=1, enable=1 -> div_err=1, clk_out stays 0. Then div=2 -> div_err=0 and clk_out toggles every cycle. Assert reset_n=0 mid-high-phase -> all outputs 0 asynchronously.
- With CLKDIV_SYNC_EN: two instances at div=6, one offset by 2 cycles; common sync pulse -> both clk_out rising edges coincident thereafter.

Source files
------------

// File: rtl/clk_divider_nway.sv
// Runtime-programmable N-way clock divider with exact 50% duty for even and odd divisors.
// Optional CLKDIV_SYNC_EN adds a sync input that forces an immediate period restart.
module clk_divider_nway #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic [WIDTH-1:0] div,
  input  logic             enable,
  output logic             clk_out,
  output logic             tick,
  output logic             active,
  output logic             div_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] div_q, div_q_next;
  logic             pos_q, pos_next;
  logic             neg_q, neg_eff;
  logic             tick_next, err_next;
  logic [WIDTH-1:0] cnt_inc, half, last;
  logic             sync_load, load;

  assign cnt_inc = cnt + 1'b1;
  assign half    = div_q >> 1;
  assign last    = div_q - 1'b1;

`ifdef CLKDIV_SYNC_EN
  assign sync_load = (state == RUN) && sync;
`else
  assign sync_load = 1'b0;
`endif

  assign load = (state == IDLE) || (cnt == last) || sync_load;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    div_q_next = div_q;
    pos_next   = pos_q;
    tick_next  = 1'b0;
    err_next   = div_err;
    if (load) begin
      if (enable && (div > WIDTH'(1))) begin
        state_next = RUN;
        div_q_next = div;
        cnt_next   = '0;
        pos_next   = 1'b1;
        tick_next  = 1'b1;
        err_next   = 1'b0;
      end else begin
        state_next = IDLE;
        pos_next   = 1'b0;
        err_next   = enable;
      end
    end else begin
      cnt_next = cnt_inc;
      pos_next = (cnt_inc < half);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= '0;
      pos_q   <= 1'b0;
      tick    <= 1'b0;
      div_err <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      div_q   <= div_q_next;
      pos_q   <= pos_next;
      tick    <= tick_next;
      div_err <= err_next;
    end
  end

  // Half-cycle extension of the high phase for odd divisors.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) neg_q <= 1'b0;
    else          neg_q <= pos_q;
  end

`ifdef CLKDIV_SYNC_EN
  // neg_q lives on the falling edge; mask it for the half cycle after a sync restart.
  logic neg_blk;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) neg_blk <= 1'b0;
    else          neg_blk <= sync_load;
  end
  assign neg_eff = neg_q & ~neg_blk;
`else
  assign neg_eff = neg_q;
`endif

  assign clk_out = div_q[0] ? (pos_q | neg_eff) : pos_q;
  assign active  = (state == RUN);

endmodule
